// File: rtl/alu.sv
// alu -- registered 8-bit arithmetic/logic unit for a 6502-compatible core.
//
// Operands A and B are combined according to OP. The result byte and the
// complete next status byte are registered on the rising edge of CLK, so a
// result appears one cycle after its inputs are sampled. The core decides
// separately whether AR and/or AF are written back.
//
// Ports:
//   CLK   in   1  system clock, rising edge
//   RSTn  in   1  asynchronous active-low reset (AR = AF = 0x00)
//   A     in   8  operand A
//   B     in   8  operand B
//   OP    in   4  operation code
//   PIN   in   8  current status, N V 1 B D I Z C (bit 7..0)
//   SUB   in   3  opcode[7:5], selects the flag touched by OP=1100
//   AR    out  8  registered result
//   AF    out  8  registered next status
//
// Configuration macro:
//   ALU_BCD_EN  when defined, ADC/SBC perform decimal adjustment while
//               PIN[3] (D) is set. When undefined, arithmetic is always
//               binary and D is only a storable flag.

module alu (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] OP,
  input  logic [7:0] PIN,
  input  logic [2:0] SUB,
  output logic [7:0] AR,
  output logic [7:0] AF
);

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_D = 3;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  logic [7:0] ar_next;
  logic [7:0] af_next;

  logic [8:0] adc_sum;
  logic [8:0] sbc_sum;
  logic [8:0] cmp_diff;

  // SBC is A + ~B + C, so carry out is the inverse of borrow.
  assign adc_sum  = {1'b0, A} + {1'b0, B}  + {8'd0, PIN[FLAG_C]};
  assign sbc_sum  = {1'b0, A} + {1'b0, ~B} + {8'd0, PIN[FLAG_C]};
  assign cmp_diff = {1'b0, A} - {1'b0, B};

  // Replace N and Z of a status byte according to value x.
  function automatic logic [7:0] set_nz(input logic [7:0] flags, input logic [7:0] x);
    logic [7:0] f;
    f = flags;
    f[FLAG_N] = x[7];
    f[FLAG_Z] = (x == 8'h00);
    return f;
  endfunction

`ifdef ALU_BCD_EN
  logic       dec_mode;
  logic [4:0] dadc_lo;
  logic       dadc_lo_carry;
  logic [3:0] dadc_lo_adj;
  logic [4:0] dadc_hi;
  logic [3:0] dadc_hi_adj;
  logic       dadc_carry;
  logic [7:0] dadc_res;
  logic       dsbc_lo_borrow;
  logic       dsbc_hi_borrow;
  logic [7:0] dsbc_res;

  assign dec_mode = PIN[FLAG_D];

  always_comb begin
    // Decimal add: adjust each nibble by 6 when it exceeds 9.
    dadc_lo       = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'd0, PIN[FLAG_C]};
    dadc_lo_carry = (dadc_lo > 5'd9);
    dadc_lo_adj   = dadc_lo_carry ? (dadc_lo[3:0] + 4'd6) : dadc_lo[3:0];
    dadc_hi       = {1'b0, A[7:4]} + {1'b0, B[7:4]} + {4'd0, dadc_lo_carry};
    dadc_carry    = (dadc_hi > 5'd9);
    dadc_hi_adj   = dadc_carry ? (dadc_hi[3:0] + 4'd6) : dadc_hi[3:0];
    dadc_res      = {dadc_hi_adj, dadc_lo_adj};

    // Decimal subtract: flags come from the binary result; only AR is fixed up.
    dsbc_lo_borrow = ({1'b0, A[3:0]} < ({1'b0, B[3:0]} + {4'd0, ~PIN[FLAG_C]}));
    dsbc_hi_borrow = ~sbc_sum[8];
    dsbc_res       = sbc_sum[7:0]
                     - (dsbc_lo_borrow ? 8'h06 : 8'h00)
                     - (dsbc_hi_borrow ? 8'h60 : 8'h00);
  end
`endif

  always_comb begin
    ar_next = A;
    af_next = PIN;

    case (OP)
      4'b0000: begin
        ar_next = A | B;
        af_next = set_nz(PIN, ar_next);
      end
      4'b0001: begin
        ar_next = A & B;
        af_next = set_nz(PIN, ar_next);
      end
      4'b0010: begin
        ar_next = A ^ B;
        af_next = set_nz(PIN, ar_next);
      end
      4'b0011: begin
        ar_next = adc_sum[7:0];
        af_next = set_nz(PIN, adc_sum[7:0]);
        af_next[FLAG_C] = adc_sum[8];
        af_next[FLAG_V] = ~(A[7] ^ B[7]) & (A[7] ^ adc_sum[7]);
`ifdef ALU_BCD_EN
        if (dec_mode) begin
          // Z tracks the binary sum; N and V see the low-adjusted value,
          // whose bit 7 is the unadjusted high-nibble sum bit 3.
          ar_next = dadc_res;
          af_next[FLAG_N] = dadc_hi[3];
          af_next[FLAG_V] = ~(A[7] ^ B[7]) & (A[7] ^ dadc_hi[3]);
          af_next[FLAG_C] = dadc_carry;
        end
`endif
      end
      4'b0100: begin
        ar_next = A;
      end
      4'b0101: begin
        ar_next = B;
        af_next = set_nz(PIN, ar_next);
      end
      4'b0110: begin
        // Compare leaves A in AR and never touches V.
        ar_next = A;
        af_next = set_nz(PIN, cmp_diff[7:0]);
        af_next[FLAG_C] = ~cmp_diff[8];
      end
      4'b0111: begin
        ar_next = sbc_sum[7:0];
        af_next = set_nz(PIN, sbc_sum[7:0]);
        af_next[FLAG_C] = sbc_sum[8];
        af_next[FLAG_V] = (A[7] ^ B[7]) & (A[7] ^ sbc_sum[7]);
`ifdef ALU_BCD_EN
        if (dec_mode) begin
          ar_next = dsbc_res;
        end
`endif
      end
      4'b1000: begin
        ar_next = {B[6:0], 1'b0};
        af_next = set_nz(PIN, ar_next);
        af_next[FLAG_C] = B[7];
      end
      4'b1001: begin
        ar_next = {B[6:0], PIN[FLAG_C]};
        af_next = set_nz(PIN, ar_next);
        af_next[FLAG_C] = B[7];
      end
      4'b1010: begin
        ar_next = {1'b0, B[7:1]};
        af_next = set_nz(PIN, ar_next);
        af_next[FLAG_C] = B[0];
      end
      4'b1011: begin
        ar_next = {PIN[FLAG_C], B[7:1]};
        af_next = set_nz(PIN, ar_next);
        af_next[FLAG_C] = B[0];
      end
      4'b1100: begin
        ar_next = A;
        case (SUB)
          3'b000:  af_next[FLAG_C] = 1'b0;
          3'b001:  af_next[FLAG_C] = 1'b1;
          3'b010:  af_next[FLAG_I] = 1'b0;
          3'b011:  af_next[FLAG_I] = 1'b1;
          3'b101:  af_next[FLAG_V] = 1'b0;
          3'b110:  af_next[FLAG_D] = 1'b0;
          3'b111:  af_next[FLAG_D] = 1'b1;
          default: af_next = PIN;
        endcase
      end
      4'b1101: begin
        ar_next = A;
        af_next[FLAG_Z] = ((A & B) == 8'h00);
        af_next[FLAG_N] = B[7];
        af_next[FLAG_V] = B[6];
      end
      4'b1110: begin
        ar_next = B - 8'd1;
        af_next = set_nz(PIN, ar_next);
      end
      default: begin
        ar_next = B + 8'd1;
        af_next = set_nz(PIN, ar_next);
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      AR <= 8'h00;
      AF <= 8'h00;
    end else begin
      AR <= ar_next;
      AF <= af_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed-vector bench for alu. Each vector lists the inputs and
// the hand-computed AR/AF expected one clock later.

module tb_alu;

  logic       CLK;
  logic       RSTn;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] OP;
  logic [7:0] PIN;
  logic [2:0] SUB;
  logic [7:0] AR;
  logic [7:0] AF;

  int vectors_applied;
  int miscompares;

  alu dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .A   (A),
    .B   (B),
    .OP  (OP),
    .PIN (PIN),
    .SUB (SUB),
    .AR  (AR),
    .AF  (AF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Drive one vector away from the edge, then check both outputs after it.
  task automatic apply(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] pin, input logic [2:0] sub,
                       input logic [7:0] exp_ar, input logic [7:0] exp_af);
    @(negedge CLK);
    OP  = op;
    A   = a;
    B   = b;
    PIN = pin;
    SUB = sub;
    @(posedge CLK);
    #1;
    $display("%-10s op=%04b a=%02h b=%02h pin=%02h sub=%03b -> ar=%02h af=%02h",
             tag, op, a, b, pin, sub, AR, AF);
    check({tag, ".ar"}, AR, exp_ar);
    check({tag, ".af"}, AF, exp_af);
  endtask

  logic [7:0] bcd_exp_ar;

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    RSTn = 1'b0;
    OP   = 4'b0000;
    A    = 8'h00;
    B    = 8'h00;
    PIN  = 8'h00;
    SUB  = 3'b000;

    // Reset state while RSTn is held low.
    repeat (2) @(posedge CLK);
    #1;
    check("rst.ar", AR, 8'h00);
    check("rst.af", AF, 8'h00);
    @(negedge CLK);
    RSTn = 1'b1;

    //     tag          op       A      B      PIN    SUB     AR     AF
    apply("adc_ovf",  4'b0011, 8'h50, 8'h50, 8'h20, 3'b000, 8'hA0, 8'hE0);
    apply("adc_cin",  4'b0011, 8'hFF, 8'h01, 8'h01, 3'b000, 8'h01, 8'h01);
    apply("sbc",      4'b0111, 8'h00, 8'h01, 8'h01, 3'b000, 8'hFF, 8'h80);
    apply("cmp_eq",   4'b0110, 8'h40, 8'h40, 8'h00, 3'b000, 8'h40, 8'h03);
    apply("cmp_lt",   4'b0110, 8'h10, 8'h20, 8'h40, 3'b000, 8'h10, 8'hC0);
    apply("ror",      4'b1011, 8'h00, 8'h01, 8'h01, 3'b000, 8'h80, 8'h81);
    apply("inc_wrap", 4'b1111, 8'h00, 8'hFF, 8'h00, 3'b000, 8'h00, 8'h02);
    apply("dec_wrap", 4'b1110, 8'h00, 8'h00, 8'h00, 3'b000, 8'hFF, 8'h80);
    apply("sec",      4'b1100, 8'h12, 8'h00, 8'h40, 3'b001, 8'h12, 8'h41);
    apply("sei",      4'b1100, 8'h00, 8'h00, 8'h40, 3'b011, 8'h00, 8'h44);
    apply("clv",      4'b1100, 8'h00, 8'h00, 8'h40, 3'b101, 8'h00, 8'h00);
    apply("sed",      4'b1100, 8'h00, 8'h00, 8'h40, 3'b111, 8'h00, 8'h48);
    apply("clc",      4'b1100, 8'h00, 8'h00, 8'hFF, 3'b000, 8'h00, 8'hFE);
    apply("cli",      4'b1100, 8'h00, 8'h00, 8'hFF, 3'b010, 8'h00, 8'hFB);
    apply("nop_flag", 4'b1100, 8'h00, 8'h00, 8'hFF, 3'b100, 8'h00, 8'hFF);
    apply("cld",      4'b1100, 8'h00, 8'h00, 8'hFF, 3'b110, 8'h00, 8'hF7);
    apply("bit",      4'b1101, 8'h0F, 8'hC0, 8'h00, 3'b000, 8'h0F, 8'hC2);
    apply("ora",      4'b0000, 8'h0F, 8'hF0, 8'h00, 3'b000, 8'hFF, 8'h80);
    apply("ora_pass", 4'b0000, 8'h01, 8'h00, 8'h30, 3'b000, 8'h01, 8'h30);
    apply("and",      4'b0001, 8'h0F, 8'hF0, 8'h00, 3'b000, 8'h00, 8'h02);
    apply("eor",      4'b0010, 8'hFF, 8'hFF, 8'h81, 3'b000, 8'h00, 8'h03);
    apply("pass_a",   4'b0100, 8'h80, 8'h11, 8'h3C, 3'b000, 8'h80, 8'h3C);
    apply("pass_b",   4'b0101, 8'h55, 8'h00, 8'h80, 3'b000, 8'h00, 8'h02);
    apply("asl",      4'b1000, 8'h00, 8'h81, 8'h00, 3'b000, 8'h02, 8'h01);
    apply("rol",      4'b1001, 8'h00, 8'h80, 8'h01, 3'b000, 8'h01, 8'h01);
    apply("lsr",      4'b1010, 8'h00, 8'h01, 8'h00, 3'b000, 8'h00, 8'h03);

    // Decimal mode only changes the result when the BCD option is built in.
`ifdef ALU_BCD_EN
    bcd_exp_ar = 8'h20;
`else
    bcd_exp_ar = 8'h1A;
`endif
    apply("adc_dec",  4'b0011, 8'h19, 8'h01, 8'h08, 3'b000, bcd_exp_ar, 8'h08);

    // Reset mid-stream: outputs clear immediately, without a clock edge.
    @(negedge CLK);
    OP  = 4'b0101;
    B   = 8'h77;
    PIN = 8'hFF;
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    check("rst_mid.ar", AR, 8'h00);
    check("rst_mid.af", AF, 8'h00);
    @(posedge CLK);
    #1;
    check("rst_hold.ar", AR, 8'h00);
    check("rst_hold.af", AF, 8'h00);
    @(negedge CLK);
    RSTn = 1'b1;

    // First edge after release loads a normal result.
    apply("post_rst", 4'b1111, 8'h00, 8'h41, 8'h00, 3'b000, 8'h42, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
